// File: rtl/led_sequencer.sv
// led_sequencer: bus-mapped LED pattern engine.
// Feeds the LED output register with static, blinking or rotating images at a
// programmable tick period, so software only has to program four registers.
// Register map (word addressed): 0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS.
// Optional build macro LED_SEQ_IRQ_EN adds an irq output that flags a wrap of
// the STATUS step counter; the default build has no irq port.
module led_sequencer #(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        led_we,
    output logic [31:0] led_din
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PUSH = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTL   = 2'd2;
    localparam logic [1:0] MODE_ROTR   = 2'd3;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_en;
    logic [1:0]         r_mode;
    logic [31:0]        r_pattern;
    logic [CNT_W-1:0]   r_period;
    logic [STEP_W-1:0]  r_steps;
    logic [31:0]        r_img;
    logic               r_phase;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_wrCtrl;
    logic               w_wrPattern;
    logic               w_wrPeriod;
    logic               w_tick;
    logic [CNT_W-1:0]   w_eff;

    assign w_wrCtrl    = WE && (Addr == 2'd0);
    assign w_wrPattern = WE && (Addr == 2'd1);
    assign w_wrPeriod  = WE && (Addr == 2'd2);

    // A zero period would never expire, so it behaves like a period of one.
    assign w_eff = (r_period == '0) ? CNT_W'(1) : r_period;

    // A step happens when the countdown expires in an animated mode; a restart
    // write in the same cycle takes priority and the step is dropped.
    assign w_tick = (r_state == RUN) && (r_cnt == '0) && (r_mode != MODE_STATIC)
                    && !w_wrCtrl && !w_wrPattern;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state logic: CTRL/PATTERN writes restart or stop the engine from any state.
    always_comb begin
        w_nextState = r_state;
        if (w_wrCtrl) begin
            w_nextState = Din[0] ? PUSH : IDLE;
        end else if (w_wrPattern && r_en) begin
            w_nextState = PUSH;
        end else begin
            case (r_state)
                IDLE:    w_nextState = IDLE;
                PUSH:    w_nextState = r_en ? RUN : IDLE;
                RUN:     w_nextState = w_tick ? PUSH : RUN;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Output logic: the LED image is presented only during the one-cycle push.
    always_comb begin
        led_we  = 1'b0;
        led_din = '0;
        if (r_state == PUSH) begin
            led_we  = 1'b1;
            led_din = ((r_mode == MODE_BLINK) && r_phase) ? 32'd0 : r_img;
        end
    end

    // Register file, working image, blink phase, step counter and tick countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_mode    <= MODE_STATIC;
            r_pattern <= '0;
            r_period  <= '0;
            r_steps   <= '0;
            r_img     <= '0;
            r_phase   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_wrCtrl) begin
                r_en   <= Din[0];
                r_mode <= Din[2:1];
                if (Din[0]) begin
                    r_img   <= r_pattern;
                    r_phase <= 1'b0;
                    r_steps <= '0;
                end
            end
            if (w_wrPattern) begin
                r_pattern <= Din;
                r_img     <= Din;
                r_phase   <= 1'b0;
            end
            if (w_wrPeriod) begin
                r_period <= Din[CNT_W-1:0];
            end
            if (r_state == PUSH) begin
                r_cnt <= w_eff - CNT_W'(1);
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_tick) begin
                case (r_mode)
                    MODE_BLINK: r_phase <= ~r_phase;
                    MODE_ROTL:  r_img   <= {r_img[30:0], r_img[31]};
                    MODE_ROTR:  r_img   <= {r_img[0], r_img[31:1]};
                    default:    r_img   <= r_img;
                endcase
                r_steps <= r_steps + STEP_W'(1);
            end
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic r_irq;
    logic w_wrStatus;

    assign w_wrStatus = WE && (Addr == 2'd3);
    assign irq        = r_irq;

    // Wrap flag: set when a step rolls the counter over, cleared by any STATUS write.
    always_ff @(posedge clk) begin
        if (reset)                         r_irq <= 1'b0;
        else if (w_wrStatus)               r_irq <= 1'b0;
        else if (w_tick && (r_steps == '1)) r_irq <= 1'b1;
    end
`endif

    // Read mux: combinational on Addr, unused bits read as zero.
    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0: Dout[2:0] = {r_mode, r_en};
            2'd1: Dout = r_pattern;
            2'd2: Dout[CNT_W-1:0] = r_period;
            2'd3: begin
                Dout[STEP_W-1:0] = r_steps;
`ifdef LED_SEQ_IRQ_EN
                Dout[31] = r_irq;
`endif
            end
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed testbench for led_sequencer; covers reset, static, rotate, blink,
// zero period, reset mid-run and (with LED_SEQ_IRQ_EN) the wrap interrupt.
module tb_led_sequencer;

`ifdef LED_SEQ_IRQ_EN
    localparam int STEP_W_TB = 2;
`else
    localparam int STEP_W_TB = 16;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        led_we;
    logic [31:0] led_din;
`ifdef LED_SEQ_IRQ_EN
    logic        irq;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    led_sequencer #(.CNT_W(32), .STEP_W(STEP_W_TB)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .led_we  (led_we),
        .led_din (led_din)
`ifdef LED_SEQ_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One register write; returns #1 after the edge that performed it.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        Addr = addr;
        Din  = data;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = '0;
    endtask

    // Combinational register read, no clock edge consumed.
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        Addr = addr;
        #1;
        data = Dout;
    endtask

    // Waits for the next push, reports its image and the idle cycles before it,
    // then steps one cycle past the push.
    task automatic collectPush(output logic [31:0] data, output int gap);
        gap = 0;
        while (!led_we && gap < 50) begin
            @(posedge clk);
            #1;
            gap++;
        end
        if (!led_we) begin
            checkOutput("pushTimeout", 32'd0, 32'd1);
            data = '0;
        end else begin
            data = led_din;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        logic [31:0] rd;
        for (int a = 0; a < 4; a++) begin
            readReg(a[1:0], rd);
            checkOutput($sformatf("%s_reg%0d", tag, a), rd, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] img;
    int          gap;
    int          weCount;
    logic [31:0] rotlExp [3];
    logic [31:0] blinkExp [3];

    initial begin
        rotlExp[0]  = 32'h8000_0000; rotlExp[1]  = 32'h0000_0001; rotlExp[2]  = 32'h0000_0002;
        blinkExp[0] = 32'h0000_00AA; blinkExp[1] = 32'h0000_0000; blinkExp[2] = 32'h0000_00AA;

        reset = 1'b1;
        Addr  = '0;
        WE    = 1'b0;
        Din   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: all registers read zero and no pushes appear.
        checkAllZero("reset");
        weCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (led_we) weCount++;
        end
        checkOutput("idleNoPush", weCount, 0);

        // Static mode: one push of the pattern and then silence.
        applyStimulus(2'd1, 32'h0000_00F0);
        checkOutput("patternWhileDisabled_we", {31'd0, led_we}, 32'd0);
        applyStimulus(2'd0, 32'h1);
        checkOutput("static_we", {31'd0, led_we}, 32'd1);
        checkOutput("static_din", led_din, 32'h0000_00F0);
        weCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (led_we) weCount++;
        end
        checkOutput("staticSilent", weCount, 0);

        // Disable: no push on the EN=0 write.
        applyStimulus(2'd0, 32'h0);
        checkOutput("disable_we", {31'd0, led_we}, 32'd0);

        // Rotate left with PERIOD=3: pushes every 4 cycles.
        applyStimulus(2'd1, 32'h8000_0000);
        applyStimulus(2'd2, 32'd3);
        readReg(2'd2, rd);
        checkOutput("periodRead", rd, 32'd3);
        applyStimulus(2'd0, 32'h5);
        readReg(2'd0, rd);
        checkOutput("ctrlRead", rd, 32'h5);
        for (int k = 0; k < 3; k++) begin
            collectPush(img, gap);
            checkOutput($sformatf("rotl_din%0d", k), img, rotlExp[k]);
            if (k > 0) checkOutput($sformatf("rotl_spacing%0d", k), gap + 1, 32'd4);
        end
        readReg(2'd3, rd);
        checkOutput("rotl_steps", rd, 32'd2);

        // Blink with PERIOD=2: image, blank, image at 3-cycle spacing.
        applyStimulus(2'd0, 32'h0);
        applyStimulus(2'd1, 32'h0000_00AA);
        applyStimulus(2'd2, 32'd2);
        applyStimulus(2'd0, 32'h3);
        for (int k = 0; k < 3; k++) begin
            collectPush(img, gap);
            checkOutput($sformatf("blink_din%0d", k), img, blinkExp[k]);
            if (k > 0) checkOutput($sformatf("blink_spacing%0d", k), gap + 1, 32'd3);
        end

        // Zero period with rotate right: 2-cycle spacing.
        applyStimulus(2'd0, 32'h0);
        applyStimulus(2'd2, 32'd0);
        applyStimulus(2'd1, 32'h1);
        applyStimulus(2'd0, 32'h7);
        collectPush(img, gap);
        checkOutput("rotr_din0", img, 32'h1);
        collectPush(img, gap);
        checkOutput("rotr_din1", img, 32'h8000_0000);
        checkOutput("rotr_spacing", gap + 1, 32'd2);

        // Reset in the middle of a run.
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset_we", {31'd0, led_we}, 32'd0);
        checkAllZero("midReset");
        reset = 1'b0;

`ifdef LED_SEQ_IRQ_EN
        // Wrap interrupt with a 2-bit step counter: rises on the 4th step.
        applyStimulus(2'd2, 32'd1);
        applyStimulus(2'd1, 32'h1);
        applyStimulus(2'd0, 32'h5);
        for (int k = 0; k < 4; k++) collectPush(img, gap);
        checkOutput("irqBeforeWrap", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("irqAfterWrap", {31'd0, irq}, 32'd1);
        readReg(2'd3, rd);
        checkOutput("irqStatus", rd, 32'h8000_0000);
        applyStimulus(2'd3, 32'h0);
        checkOutput("irqCleared", {31'd0, irq}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
